// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - load/store unit driving a word-aligned data bus with strobes and load extension
module lsu_bus_master #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        mem_we,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic          to_err_q;

    logic [1:0]    size;
    logic          uns;
    logic          misaligned;
    logic          aligned_req;
    logic [3:0]    strb;
    logic [31:0]   lane_wdata;

    // size: 0 byte, 1 half, 2 word
    always_comb begin
        size = 2'd2;
        uns  = 1'b0;
        if (mem_we) begin
            case (store_type)
                2'b00:   size = 2'd0;
                2'b01:   size = 2'd1;
                default: size = 2'd2;
            endcase
        end else begin
            case (load_type)
                3'b000:  size = 2'd0;
                3'b001:  size = 2'd1;
                3'b100: begin size = 2'd0; uns = 1'b1; end
                3'b101: begin size = 2'd1; uns = 1'b1; end
                default: size = 2'd2;
            endcase
        end
    end

    always_comb begin
        strb       = 4'b1111;
        lane_wdata = wdata;
        case (size)
            2'd0: begin
                strb       = 4'b0001 << addr[1:0];
                lane_wdata = {4{wdata[7:0]}};
            end
            2'd1: begin
                strb       = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign misaligned  = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
    assign aligned_req = (state == IDLE) && req_valid && !misaligned;

    assign stall     = (state == REQ) || (state == WAIT_R) || aligned_req;
    assign err       = ((state == IDLE) && req_valid && misaligned) || to_err_q;
    assign bus_valid = (state == REQ);

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    extend = u ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    extend = u ? {16'h0, h} : {{16{h[15]}}, h};
            default: extend = w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            off_q     <= 2'd0;
            to_err_q  <= 1'b0;
            rdata     <= 32'h0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wstrb <= 4'h0;
            bus_wdata <= 32'h0;
        end else begin
            to_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (aligned_req) begin
                        state     <= REQ;
                        cnt       <= '0;
                        size_q    <= size;
                        uns_q     <= uns;
                        off_q     <= addr[1:0];
                        bus_we    <= mem_we;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wstrb <= mem_we ? strb : 4'b0000;
                        bus_wdata <= mem_we ? lane_wdata : 32'h0;
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        if (bus_we) begin
                            state <= DONE;
                        end else if (bus_rvalid) begin
                            rdata <= extend(bus_rdata, size_q, uns_q, off_q);
                            state <= DONE;
                        end else begin
                            state <= WAIT_R;
                            cnt   <= '0;
                        end
                    end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
                        to_err_q <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        rdata <= extend(bus_rdata, size_q, uns_q, off_q);
                        state <= DONE;
                    end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
                        to_err_q <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - directed self-checking bench for lsu_bus_master
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  store_type = 2'b00;
    logic [2:0]  load_type = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int n_checks = 0;
    int n_fail = 0;

    // results of the most recent access
    int          stall_cycles;
    int          err_cycles;
    int          valid_cycles;
    logic        hung;
    logic [31:0] seen_addr;
    logic [3:0]  seen_wstrb;
    logic [31:0] seen_wdata;
    logic        seen_we;
    logic [31:0] done_rdata;
    logic        done_valid;

    lsu_bus_master #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .mem_we(mem_we),
        .store_type(store_type), .load_type(load_type), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .err(err), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Runs one core request against a slave that accepts after rdy_dly waiting
    // cycles and returns read data rv_dly cycles after the accept cycle.
    task automatic run_access(input logic we, input logic [1:0] st, input logic [2:0] lt,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int rdy_dly, input int rv_dly, input logic [31:0] word);
        logic finished;
        logic accepted;
        int   req_cnt;
        int   rv_cnt;
        finished = 1'b0; accepted = 1'b0; req_cnt = 0; rv_cnt = 0;
        stall_cycles = 0; err_cycles = 0; valid_cycles = 0;
        seen_addr = 32'h0; seen_wstrb = 4'h0; seen_wdata = 32'h0; seen_we = 1'b0;
        done_rdata = 32'h0; done_valid = 1'b0;
        @(posedge clk); #2;
        req_valid = 1'b1; mem_we = we; store_type = st; load_type = lt; addr = a; wdata = wd;
        for (int c = 0; c < 30 && !finished; c++) begin
            bus_ready  = bus_valid && (req_cnt >= rdy_dly);
            bus_rdata  = word;
            bus_rvalid = !we && ((bus_valid && bus_ready && rv_dly == 0) ||
                                 (accepted && rv_cnt == rv_dly));
            #1;
            if (bus_valid) begin
                valid_cycles++;
                seen_addr = bus_addr; seen_wstrb = bus_wstrb;
                seen_wdata = bus_wdata; seen_we = bus_we;
            end
            if (err) err_cycles++;
            if (stall) stall_cycles++;
            else begin
                finished = 1'b1;
                done_rdata = rdata;
                done_valid = bus_valid;
            end
            if (accepted) rv_cnt++;
            if (bus_valid && bus_ready) begin accepted = 1'b1; rv_cnt = 1; end
            if (bus_valid && !bus_ready) req_cnt++;
            if (!finished) begin @(posedge clk); #2; end
        end
        hung = !finished;
        req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({stall, err, bus_valid, bus_we, bus_wstrb} !== 8'h00 ||
            rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: stall=%b err=%b valid=%b we=%b wstrb=%h rdata=%h addr=%h wdata=%h, required all 0",
                     stall, err, bus_valid, bus_we, bus_wstrb, rdata, bus_addr, bus_wdata);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_store_word;
        run_access(1'b1, 2'b10, 3'b000, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        n_checks++;
        if (hung || seen_addr !== 32'h100 || seen_wstrb !== 4'hF || seen_wdata !== 32'hDEADBEEF || seen_we !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_bus: hung=%b addr=%h wstrb=%h wdata=%h we=%b, required 0 100 f deadbeef 1",
                     hung, seen_addr, seen_wstrb, seen_wdata, seen_we);
        end
        n_checks++;
        if (stall_cycles != 2 || err_cycles != 0) begin
            n_fail++;
            $display("FAIL sw_stall: stall=%0d err=%0d, required 2 0", stall_cycles, err_cycles);
        end
    endtask

    task automatic test_store_lanes;
        run_access(1'b1, 2'b00, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);
        n_checks++;
        if (seen_addr !== 32'h100 || seen_wstrb !== 4'b1000 || seen_wdata !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL sb_lane: addr=%h wstrb=%b wdata=%h, required 100 1000 a5a5a5a5",
                     seen_addr, seen_wstrb, seen_wdata);
        end
        run_access(1'b1, 2'b01, 3'b000, 32'h202, 32'h00001234, 1, 0, 32'h0);
        n_checks++;
        if (seen_addr !== 32'h200 || seen_wstrb !== 4'b1100 || seen_wdata !== 32'h12341234 || stall_cycles != 3) begin
            n_fail++;
            $display("FAIL sh_lane: addr=%h wstrb=%b wdata=%h stall=%0d, required 200 1100 12341234 3",
                     seen_addr, seen_wstrb, seen_wdata, stall_cycles);
        end
    endtask

    task automatic test_load_byte;
        run_access(1'b0, 2'b00, 3'b000, 32'h101, 32'h0, 0, 0, 32'h00008000);
        n_checks++;
        if (hung || done_rdata !== 32'hFFFFFF80 || seen_wstrb !== 4'b0000 || seen_we !== 1'b0 || stall_cycles != 2) begin
            n_fail++;
            $display("FAIL lb: hung=%b rdata=%h wstrb=%b we=%b stall=%0d, required 0 ffffff80 0000 0 2",
                     hung, done_rdata, seen_wstrb, seen_we, stall_cycles);
        end
        run_access(1'b0, 2'b00, 3'b100, 32'h101, 32'h0, 0, 0, 32'h00008000);
        n_checks++;
        if (done_rdata !== 32'h00000080) begin
            n_fail++;
            $display("FAIL lbu: rdata=%h, required 00000080", done_rdata);
        end
    endtask

    task automatic test_load_half;
        run_access(1'b0, 2'b00, 3'b001, 32'h102, 32'h0, 0, 3, 32'h80010000);
        n_checks++;
        if (hung || done_rdata !== 32'hFFFF8001 || stall_cycles != 5 || valid_cycles != 1) begin
            n_fail++;
            $display("FAIL lh_late: hung=%b rdata=%h stall=%0d valid=%0d, required 0 ffff8001 5 1",
                     hung, done_rdata, stall_cycles, valid_cycles);
        end
        run_access(1'b0, 2'b00, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80010000);
        n_checks++;
        if (done_rdata !== 32'h00008001) begin
            n_fail++;
            $display("FAIL lhu: rdata=%h, required 00008001", done_rdata);
        end
    endtask

    task automatic test_misaligned;
        run_access(1'b0, 2'b00, 3'b010, 32'h102, 32'h0, 0, 0, 32'h12345678);
        n_checks++;
        if (err_cycles != 1 || stall_cycles != 0 || valid_cycles != 0) begin
            n_fail++;
            $display("FAIL lw_misaligned: err=%0d stall=%0d valid=%0d, required 1 0 0",
                     err_cycles, stall_cycles, valid_cycles);
        end
        run_access(1'b1, 2'b01, 3'b000, 32'h301, 32'h0000BEEF, 0, 0, 32'h0);
        n_checks++;
        if (err_cycles != 1 || stall_cycles != 0 || valid_cycles != 0) begin
            n_fail++;
            $display("FAIL sh_misaligned: err=%0d stall=%0d valid=%0d, required 1 0 0",
                     err_cycles, stall_cycles, valid_cycles);
        end
        run_access(1'b0, 2'b00, 3'b000, 32'h103, 32'h0, 0, 0, 32'h7F000000);
        n_checks++;
        if (err_cycles != 0 || done_rdata !== 32'h0000007F) begin
            n_fail++;
            $display("FAIL lb_odd_addr: err=%0d rdata=%h, required 0 0000007f", err_cycles, done_rdata);
        end
    endtask

    task automatic test_back_to_back;
        run_access(1'b0, 2'b00, 3'b010, 32'h400, 32'h0, 0, 1, 32'hCAFEF00D);
        n_checks++;
        if (done_rdata !== 32'hCAFEF00D || stall_cycles != 3) begin
            n_fail++;
            $display("FAIL lw_then: rdata=%h stall=%0d, required cafef00d 3", done_rdata, stall_cycles);
        end
        run_access(1'b1, 2'b11, 3'b000, 32'h404, 32'h11223344, 0, 0, 32'h0);
        n_checks++;
        if (done_rdata !== 32'hCAFEF00D || seen_wstrb !== 4'hF || seen_wdata !== 32'h11223344) begin
            n_fail++;
            $display("FAIL store_keeps_rdata: rdata=%h wstrb=%h wdata=%h, required cafef00d f 11223344",
                     done_rdata, seen_wstrb, seen_wdata);
        end
    endtask

    task automatic test_timeout;
        run_access(1'b1, 2'b10, 3'b000, 32'h500, 32'h55555555, 1000, 0, 32'h0);
        n_checks++;
        if (hung || valid_cycles != 4 || err_cycles != 1 || stall_cycles != 5 || done_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_req: hung=%b valid=%0d err=%0d stall=%0d done_valid=%b, required 0 4 1 5 0",
                     hung, valid_cycles, err_cycles, stall_cycles, done_valid);
        end
        n_checks++;
        if (done_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL timeout_rdata: rdata=%h, required cafef00d", done_rdata);
        end
        @(posedge clk); #3;
        n_checks++;
        if (stall !== 1'b0 || err !== 1'b0 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: stall=%b err=%b valid=%b, required 0 0 0", stall, err, bus_valid);
        end
    endtask

    task automatic test_reset_mid_transfer;
        @(posedge clk); #2;
        req_valid = 1'b1; mem_we = 1'b0; load_type = 3'b010; addr = 32'h600;
        @(posedge clk); #2;
        bus_ready = 1'b1;
        @(posedge clk); #2;
        bus_ready = 1'b0; req_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_r_entry: stall=%b valid=%b, required 1 0", stall, bus_valid);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({stall, err, bus_valid, bus_we, bus_wstrb} !== 8'h00 ||
            rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: stall=%b err=%b valid=%b we=%b wstrb=%h rdata=%h addr=%h, required all 0",
                     stall, err, bus_valid, bus_we, bus_wstrb, rdata, bus_addr);
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #2;
        bus_rvalid = 1'b0;
        #1;
        n_checks++;
        if (rdata !== 32'h0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_rvalid: rdata=%h stall=%b, required 0 0", rdata, stall);
        end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_store_lanes;
        test_load_byte;
        test_load_half;
        test_misaligned;
        test_back_to_back;
        test_timeout;
        test_reset_mid_transfer;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
